// File: rtl/spi_slave_driver.sv
// SPI responder, CPOL=0/CPHA=0, MSB first, 8-bit frames, with pins oversampled on clk_i.
// Received bytes are strobed out. TX bytes pass through a one-entry buffer with no bypass.
module spi_slave_driver #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_bi,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_bo,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o,
  input  logic       spi_sclk_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift, r_tx_shift, r_buf, r_rx_data;
  logic                   r_full, r_rx_valid, r_underrun, r_miso;
  state_t                 r_state, w_state_nxt;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sel, w_desel, w_rise, w_last, w_load, w_write;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_sel   = !w_cs_s && r_cs_d;
  assign w_desel = w_cs_s && !r_cs_d;
  assign w_rise  = w_sclk_s && !r_sclk_d && !w_cs_s;
  assign w_last  = w_rise && (r_bit_cnt == 3'd7);
  assign w_load  = w_sel || w_last;
  assign w_write = tx_valid_i && !r_full;

  // Equal-depth chains keep mosi_s aligned with the sclk_s edge that samples it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_sel)   w_state_nxt = ACTIVE;
      ACTIVE:  if (w_desel) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A load samples the buffer before this cycle's write lands, so a
  // colliding write waits for the next load point.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf  <= 8'h00;
      r_full <= 1'b0;
    end else begin
      if (w_load)  r_full <= 1'b0;
      if (w_write) begin
        r_buf  <= tx_data_bi;
        r_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= w_last;
      r_underrun <= w_load && !r_full;
      r_miso     <= r_tx_shift[7] && !w_cs_s;
      if (w_desel) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_tx_shift <= 8'h00;
      end else begin
        if (w_rise) begin
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
        end
        if (w_last) r_rx_data <= {r_rx_shift[6:0], w_mosi_s};
        if (w_load)      r_tx_shift <= r_full ? r_buf : IDLE_BYTE;
        else if (w_rise) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
    end
  end

  assign tx_ready_o    = !r_full;
  assign rx_data_bo    = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign tx_underrun_o = r_underrun;
  assign busy_o        = (r_state == ACTIVE);
  assign spi_miso_o    = r_miso;

endmodule
